systolic_array_ctrl: RTL and testbench

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

---
 rtl/systolic_array_ctrl_pkg.sv | 35 +++
 rtl/systolic_array_ctrl_if.sv | 43 ++++
 rtl/sa_skew_mux.sv | 37 +++
 rtl/systolic_array_ctrl.sv | 174 +++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_array_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl_pkg
// Shared definitions for the 4x4 systolic array controller: FSM state
// encoding, array dimension, feed length and the skew index helpers used to
// map a feed beat onto the operand buffers.
// No ports (package).
// -----------------------------------------------------------------------------
package systolic_array_ctrl_pkg;

   // Array dimension and the number of feed beats needed to push a full
   // skewed wavefront through it.
   localparam int unsigned N       = 4;
   localparam int unsigned FeedLen = 2 * N - 1;
   localparam int unsigned BeatW   = 3;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StClear = 3'd1,
      StFeed  = 3'd2,
      StDrain = 3'd3,
      StLoad  = 3'd4,
      StDone  = 3'd5
   } state_e;

   // Lane k carries element (beat - k) of its row/column while that offset is
   // inside the array; outside that window the lane is idle.
   function automatic logic skew_valid(input int unsigned beat, input int unsigned lane);
      return (beat >= lane) && ((beat - lane) < N);
   endfunction

   function automatic logic [1:0] skew_idx(input int unsigned beat, input int unsigned lane);
      return 2'(beat - lane);
   endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl_if
// Bundles the operand-write bus, run control and array edge outputs of the
// systolic array controller.
//   master : drives wr_en/wr_sel/wr_addr/wr_data/start, observes the rest
//   slave  : the controller itself
// Parameter DATA_WIDTH: west operand width; north operands/write data are 2x.
// -----------------------------------------------------------------------------
interface systolic_array_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                      wr_en;
   logic                      wr_sel;
   logic [3:0]                wr_addr;
   logic [2*DATA_WIDTH-1:0]   wr_data;
   logic                      start;
   logic                      busy;
   logic                      done;
   logic                      sa_clr;
   logic                      result_ld;
   logic [DATA_WIDTH-1:0]     fd_w0;
   logic [DATA_WIDTH-1:0]     fd_w1;
   logic [DATA_WIDTH-1:0]     fd_w2;
   logic [DATA_WIDTH-1:0]     fd_w3;
   logic [2*DATA_WIDTH-1:0]   rd_n0;
   logic [2*DATA_WIDTH-1:0]   rd_n1;
   logic [2*DATA_WIDTH-1:0]   rd_n2;
   logic [2*DATA_WIDTH-1:0]   rd_n3;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  busy, done, sa_clr, result_ld,
      input  fd_w0, fd_w1, fd_w2, fd_w3,
      input  rd_n0, rd_n1, rd_n2, rd_n3
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output busy, done, sa_clr, result_ld,
      output fd_w0, fd_w1, fd_w2, fd_w3,
      output rd_n0, rd_n1, rd_n2, rd_n3
   );
endinterface

// File: rtl/sa_skew_mux.sv
// -----------------------------------------------------------------------------
// sa_skew_mux
// Combinational map from (feed flag, beat, operand buffers) to the eight
// skewed edge values of the array.
//   i_feed : 1 when the values are for a FEED beat; otherwise all lanes are 0
//   i_beat : feed beat 0..6
//   i_a    : A buffer [row][col], DATA_WIDTH
//   i_b    : B buffer [row][col], 2*DATA_WIDTH
//   o_w    : west inputs, row i gets A[i][beat-i]
//   o_n    : north inputs, column j gets B[beat-j][j]
// -----------------------------------------------------------------------------
module sa_skew_mux
   import systolic_array_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                    i_feed,
   input  logic [BeatW-1:0]        i_beat,
   input  logic [DATA_WIDTH-1:0]   i_a [N][N],
   input  logic [2*DATA_WIDTH-1:0] i_b [N][N],
   output logic [DATA_WIDTH-1:0]   o_w [N],
   output logic [2*DATA_WIDTH-1:0] o_n [N]
);

   logic [N-1:0] w_hit;
   logic [1:0]   w_idx [N];

   for (genvar k = 0; k < N; k++) begin : g_lane
      // Row k and column k share the same skew offset, so one hit/index
      // pair serves both edges.
      assign w_hit[k] = i_feed && skew_valid(32'(i_beat), k);
      assign w_idx[k] = skew_idx(32'(i_beat), k);
      assign o_w[k]   = w_hit[k] ? i_a[k][w_idx[k]] : '0;
      assign o_n[k]   = w_hit[k] ? i_b[w_idx[k]][k] : '0;
   end

endmodule

// File: rtl/systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl
// Sequencer for a 4x4 output-stationary systolic array. Holds the A (west)
// and B (north) operand buffers, and per run issues: accumulator clear,
// seven skewed feed beats, DRAIN_CYCLES idle beats, a result capture strobe
// and a done pulse.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : systolic_array_ctrl_if.slave (write bus, start, status, edge data)
// Parameters:
//   DATA_WIDTH   : west operand width (north/write data are 2*DATA_WIDTH)
//   DRAIN_CYCLES : idle beats between last feed beat and result_ld
// -----------------------------------------------------------------------------
module systolic_array_ctrl
   import systolic_array_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_array_ctrl_if.slave bus
);

   localparam int unsigned        DrainW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DrainW-1:0]  DrainLast = (DRAIN_CYCLES == 0) ? '0 : DrainW'(DRAIN_CYCLES - 1);
   localparam logic [BeatW-1:0]   FeedLast  = BeatW'(FeedLen - 1);

   state_e                  r_state, w_state_d;
   logic [BeatW-1:0]        r_beat, w_beat_d;
   logic [DrainW-1:0]       r_drain, w_drain_d;

   logic [DATA_WIDTH-1:0]   r_a [N][N];
   logic [2*DATA_WIDTH-1:0] r_b [N][N];

   logic                    r_busy, r_done, r_sa_clr, r_result_ld;
   logic                    w_busy_d, w_done_d, w_sa_clr_d, w_result_ld_d, w_feed_d;
   logic [DATA_WIDTH-1:0]   r_fd [N];
   logic [2*DATA_WIDTH-1:0] r_rd [N];
   logic [DATA_WIDTH-1:0]   w_fd_d [N];
   logic [2*DATA_WIDTH-1:0] w_rd_d [N];

   // ---------------------------------------------------------------- buffers
   // Writes are only honoured in IDLE, so the buffers are stable for a whole
   // run. A write in the same cycle as start still lands before FEED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_a[i][j] <= '0;
               r_b[i][j] <= '0;
            end
         end
      end else if (bus.wr_en && (r_state == StIdle)) begin
         if (bus.wr_sel) begin
            r_b[bus.wr_addr[3:2]][bus.wr_addr[1:0]] <= bus.wr_data;
         end else begin
            r_a[bus.wr_addr[3:2]][bus.wr_addr[1:0]] <= bus.wr_data[DATA_WIDTH-1:0];
         end
      end
   end

   // ----------------------------------------------------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_beat  <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_d;
         r_beat  <= w_beat_d;
         r_drain <= w_drain_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_state_d = r_state;
      w_beat_d  = r_beat;
      w_drain_d = r_drain;
      case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_state_d = StClear;
            end
         end
         StClear: begin
            w_state_d = StFeed;
            w_beat_d  = '0;
         end
         StFeed: begin
            if (r_beat == FeedLast) begin
               w_beat_d  = '0;
               w_drain_d = '0;
               w_state_d = (DRAIN_CYCLES == 0) ? StLoad : StDrain;
            end else begin
               w_beat_d = r_beat + 1'b1;
            end
         end
         StDrain: begin
            if (r_drain == DrainLast) begin
               w_drain_d = '0;
               w_state_d = StLoad;
            end else begin
               w_drain_d = r_drain + 1'b1;
            end
         end
         StLoad:  w_state_d = StDone;
         StDone:  w_state_d = StIdle;
         default: begin
            w_state_d = StIdle;
            w_beat_d  = '0;
            w_drain_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Outputs are decoded from the next state and registered, so each flop
   // changes on the same edge as r_state and always matches the current state.
   always_comb begin
      w_busy_d      = (w_state_d != StIdle);
      w_sa_clr_d    = (w_state_d == StClear);
      w_feed_d      = (w_state_d == StFeed);
      w_result_ld_d = (w_state_d == StLoad);
      w_done_d      = (w_state_d == StDone);
   end

   sa_skew_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skew_mux (
      .i_feed (w_feed_d),
      .i_beat (w_beat_d),
      .i_a    (r_a),
      .i_b    (r_b),
      .o_w    (w_fd_d),
      .o_n    (w_rd_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sa_clr    <= 1'b0;
         r_result_ld <= 1'b0;
         for (int k = 0; k < N; k++) begin
            r_fd[k] <= '0;
            r_rd[k] <= '0;
         end
      end else begin
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_sa_clr    <= w_sa_clr_d;
         r_result_ld <= w_result_ld_d;
         r_fd        <= w_fd_d;
         r_rd        <= w_rd_d;
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.sa_clr    = r_sa_clr;
   assign bus.result_ld = r_result_ld;
   assign bus.fd_w0     = r_fd[0];
   assign bus.fd_w1     = r_fd[1];
   assign bus.fd_w2     = r_fd[2];
   assign bus.fd_w3     = r_fd[3];
   assign bus.rd_n0     = r_rd[0];
   assign bus.rd_n1     = r_rd[1];
   assign bus.rd_n2     = r_rd[2];
   assign bus.rd_n3     = r_rd[3];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_ctrl
// Directed bench for systolic_array_ctrl. dut0 uses default parameters,
// dut1 uses DRAIN_CYCLES=0. Cycle index k counts rising edges since the
// edge that sampled start (k=1 is CLEAR, k=2..8 are feed beats 0..6).
// -----------------------------------------------------------------------------
module tb_systolic_array_ctrl;

   logic clk;
   logic rst;

   int errors = 0;
   int checks = 0;

   // Reference copy of dut0's operand buffers.
   logic [15:0] ma [4][4];
   logic [31:0] mb [4][4];

   systolic_array_ctrl_if #(.DATA_WIDTH(16)) bus0 ();
   systolic_array_ctrl_if #(.DATA_WIDTH(16)) bus1 ();

   systolic_array_ctrl #(.DATA_WIDTH(16), .DRAIN_CYCLES(4)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   systolic_array_ctrl #(.DATA_WIDTH(16), .DRAIN_CYCLES(0)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [191:0] lanes0();
      return {bus0.rd_n3, bus0.rd_n2, bus0.rd_n1, bus0.rd_n0,
              bus0.fd_w3, bus0.fd_w2, bus0.fd_w1, bus0.fd_w0};
   endfunction

   // Expected edge values for feed beat b from the reference buffers.
   function automatic logic [191:0] exp_lanes(input int b);
      logic [191:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) begin
         if ((b - i >= 0) && (b - i <= 3)) begin
            v[i*16 +: 16]      = ma[i][b-i];
            v[64 + i*32 +: 32] = mb[b-i][i];
         end
      end
      return v;
   endfunction

   task automatic write_elem(input logic sel, input logic [3:0] addr, input logic [31:0] data);
      bus0.wr_en   = 1'b1;
      bus0.wr_sel  = sel;
      bus0.wr_addr = addr;
      bus0.wr_data = data;
      tick();
      bus0.wr_en   = 1'b0;
      if (sel) mb[addr[3:2]][addr[1:0]] = data;
      else     ma[addr[3:2]][addr[1:0]] = data[15:0];
   endtask

   task automatic pulse_start0();
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if (bus0.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b want 0", bus0.busy);
      end
      checks++;
      if ({bus0.done, bus0.sa_clr, bus0.result_ld} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 000", {bus0.done, bus0.sa_clr, bus0.result_ld});
      end
      checks++;
      if (lanes0() !== 192'd0) begin
         errors++; $display("FAIL reset_lanes: got %h want 0", lanes0());
      end
      checks++;
      if (bus1.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy_d0: got %b want 0", bus1.busy);
      end
      rst = 1'b0;
      tick();
   endtask

   // A = identity, B[k][j] = 16k+j
   task automatic test_identity();
      int busy_cnt, ld_at, ld_cnt, done_at;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            write_elem(1'b0, 4'(i*4 + j), (i == j) ? 32'd1 : 32'd0);
            write_elem(1'b1, 4'(i*4 + j), 32'(16*i + j));
         end
      end
      pulse_start0();
      checks++;
      if ({bus0.busy, bus0.sa_clr} !== 2'b11) begin
         errors++; $display("FAIL id_clear: got %b want 11", {bus0.busy, bus0.sa_clr});
      end
      busy_cnt = 1; ld_at = -1; ld_cnt = 0; done_at = -1;
      for (int k = 2; k <= 20; k++) begin
         tick();
         if (bus0.busy) busy_cnt++;
         if (bus0.result_ld) begin ld_cnt++; ld_at = k; end
         if (bus0.done) done_at = k;
         if (k >= 2 && k <= 8) begin
            checks++;
            if (lanes0() !== exp_lanes(k - 2)) begin
               errors++;
               $display("FAIL id_beat%0d: got %h want %h", k - 2, lanes0(), exp_lanes(k - 2));
            end
         end
         if (k == 5) begin
            checks++;
            if ({bus0.rd_n0, bus0.rd_n3} !== {32'h30, 32'h03}) begin
               errors++;
               $display("FAIL id_b3_north: got %h %h want 30 03", bus0.rd_n0, bus0.rd_n3);
            end
            // Row 3 carries A[3][0] at beat 3; its diagonal 1 arrives at beat 6.
            checks++;
            if ({bus0.fd_w0, bus0.fd_w3} !== {16'h0, 16'h0}) begin
               errors++;
               $display("FAIL id_b3_west: got %h %h want 0 0", bus0.fd_w0, bus0.fd_w3);
            end
         end
         if (k == 8) begin
            checks++;
            if (bus0.fd_w3 !== 16'h1) begin
               errors++; $display("FAIL id_b6_w3: got %h want 1", bus0.fd_w3);
            end
         end
      end
      checks++;
      if (busy_cnt !== 14) begin
         errors++; $display("FAIL id_busy_len: got %0d want 14", busy_cnt);
      end
      checks++;
      if (ld_at !== 13 || ld_cnt !== 1) begin
         errors++; $display("FAIL id_result_ld: got at %0d count %0d want at 13 count 1", ld_at, ld_cnt);
      end
      checks++;
      if (done_at !== 14) begin
         errors++; $display("FAIL id_done: got %0d want 14", done_at);
      end
   endtask

   task automatic test_start_ignored();
      int clr_cnt, done_cnt, done_at;
      pulse_start0();
      clr_cnt = 0; done_cnt = 0; done_at = -1;
      for (int k = 2; k <= 24; k++) begin
         tick();
         bus0.start = (k == 4);
         if (bus0.sa_clr) clr_cnt++;
         if (bus0.done) begin done_cnt++; done_at = k; end
         if (k == 5) begin
            checks++;
            if (lanes0() !== exp_lanes(3)) begin
               errors++; $display("FAIL ign_beat3: got %h want %h", lanes0(), exp_lanes(3));
            end
         end
      end
      bus0.start = 1'b0;
      checks++;
      if (clr_cnt !== 0) begin
         errors++; $display("FAIL ign_restart: got %0d clears want 0", clr_cnt);
      end
      checks++;
      if (done_cnt !== 1 || done_at !== 14) begin
         errors++; $display("FAIL ign_done: got count %0d at %0d want count 1 at 14", done_cnt, done_at);
      end
   endtask

   task automatic test_write_in_drain();
      pulse_start0();
      for (int k = 2; k <= 16; k++) begin
         tick();
         bus0.wr_en   = (k == 9);
         bus0.wr_sel  = 1'b0;
         bus0.wr_addr = 4'h0;
         bus0.wr_data = 32'h55;
      end
      bus0.wr_en = 1'b0;
      pulse_start0();
      tick();
      checks++;
      if (bus0.fd_w0 !== 16'h0001) begin
         errors++; $display("FAIL drainwr_fd_w0: got %h want 0001", bus0.fd_w0);
      end
      checks++;
      if (lanes0() !== exp_lanes(0)) begin
         errors++; $display("FAIL drainwr_beat0: got %h want %h", lanes0(), exp_lanes(0));
      end
      repeat (14) tick();
   endtask

   task automatic test_reset_mid_run();
      int bad;
      pulse_start0();
      repeat (5) tick();
      checks++;
      if ({bus0.busy, lanes0() != 192'd0} !== 2'b11) begin
         errors++; $display("FAIL rstmid_pre: got busy %b lanes %h want busy 1 nonzero", bus0.busy, lanes0());
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus0.busy, bus0.done, bus0.sa_clr, bus0.result_ld} !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_ctl: got %b want 0000",
                  {bus0.busy, bus0.done, bus0.sa_clr, bus0.result_ld});
      end
      checks++;
      if (lanes0() !== 192'd0) begin
         errors++; $display("FAIL rstmid_lanes: got %h want 0", lanes0());
      end
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ma[i][j] = '0;
            mb[i][j] = '0;
         end
      end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus0.result_ld || bus0.done || bus0.busy) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", bad);
      end
      pulse_start0();
      bad = 0;
      for (int k = 2; k <= 16; k++) begin
         tick();
         if (lanes0() !== 192'd0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL rstmid_bufs_zero: got %0d nonzero beats want 0", bad);
      end
   endtask

   task automatic test_write_with_start();
      bus0.wr_en   = 1'b1;
      bus0.wr_sel  = 1'b1;
      bus0.wr_addr = 4'h0;
      bus0.wr_data = 32'h1234;
      bus0.start   = 1'b1;
      tick();
      bus0.wr_en = 1'b0;
      bus0.start = 1'b0;
      mb[0][0] = 32'h1234;
      tick();
      checks++;
      if (bus0.rd_n0 !== 32'h1234) begin
         errors++; $display("FAIL wrstart_rd_n0: got %h want 00001234", bus0.rd_n0);
      end
      checks++;
      if ({bus0.fd_w0, bus0.rd_n1} !== {16'h0, 32'h0}) begin
         errors++; $display("FAIL wrstart_others: got %h %h want 0 0", bus0.fd_w0, bus0.rd_n1);
      end
      repeat (14) tick();
   endtask

   task automatic test_back_to_back();
      int done_at;
      pulse_start0();
      done_at = -1;
      for (int k = 2; k <= 14; k++) begin
         tick();
         if (bus0.done) done_at = k;
      end
      checks++;
      if (done_at !== 14) begin
         errors++; $display("FAIL b2b_first_done: got %0d want 14", done_at);
      end
      tick();
      checks++;
      if (bus0.busy !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: got busy %b want 0", bus0.busy);
      end
      pulse_start0();
      checks++;
      if ({bus0.busy, bus0.sa_clr} !== 2'b11) begin
         errors++; $display("FAIL b2b_restart: got %b want 11", {bus0.busy, bus0.sa_clr});
      end
      done_at = -1;
      for (int k = 2; k <= 16; k++) begin
         tick();
         if (bus0.done) done_at = k;
      end
      checks++;
      if (done_at !== 14) begin
         errors++; $display("FAIL b2b_second_done: got %0d want 14", done_at);
      end
   endtask

   task automatic test_drain0();
      int busy_cnt, ld_at, done_at;
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      busy_cnt = bus1.busy ? 1 : 0;
      ld_at = -1; done_at = -1;
      for (int k = 2; k <= 16; k++) begin
         tick();
         if (bus1.busy) busy_cnt++;
         if (bus1.result_ld) ld_at = k;
         if (bus1.done) done_at = k;
      end
      checks++;
      if (ld_at !== 9) begin
         errors++; $display("FAIL d0_result_ld: got %0d want 9", ld_at);
      end
      checks++;
      if (busy_cnt !== 10) begin
         errors++; $display("FAIL d0_busy_len: got %0d want 10", busy_cnt);
      end
      checks++;
      if (done_at !== 10) begin
         errors++; $display("FAIL d0_done: got %0d want 10", done_at);
      end
   endtask

   initial begin
      rst = 1'b1;
      {bus0.wr_en, bus0.wr_sel, bus0.wr_addr, bus0.wr_data, bus0.start} = '0;
      {bus1.wr_en, bus1.wr_sel, bus1.wr_addr, bus1.wr_data, bus1.start} = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ma[i][j] = '0;
            mb[i][j] = '0;
         end
      end
      test_reset();
      test_identity();
      test_start_ignored();
      test_write_in_drain();
      test_reset_mid_run();
      test_write_with_start();
      test_back_to_back();
      test_drain0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
